// File: rtl/config_register_bank.sv
// Password-protected bank of NUM_REGS config registers with retry lockout and grant/write handshake.
// All outputs registered (1 cycle after the causing edge); no backpressure, inputs are sampled on confirm edges.
module config_register_bank #(
  parameter int DATA_WIDTH  = 7,
  parameter int NUM_REGS    = 2,
  parameter int KEY_WIDTH   = 8,
  parameter logic [KEY_WIDTH-1:0] PASSWORD = 8'hA5,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 16,
  localparam int SEL_WIDTH  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           request,
  input  logic                           confirm,
  input  logic [KEY_WIDTH-1:0]           key,
  input  logic [SEL_WIDTH-1:0]           regSelect,
  input  logic [DATA_WIDTH-1:0]          inputData,
  output logic [NUM_REGS*DATA_WIDTH-1:0] dataOut,
  output logic                           granted,
  output logic                           denied,
  output logic                           locked,
  output logic                           writeDone
);

  localparam int FW = $clog2(MAX_TRIES + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam logic [SEL_WIDTH:0] NUM_REGS_W = (SEL_WIDTH + 1)'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, CHECK, GRANTED, LOCKED} state_t;

  state_t                          state, state_nxt;
  logic [FW-1:0]                   fail_count, fail_nxt, fail_inc;
  logic [LW-1:0]                   lock_count, lock_nxt;
  logic                            confirm_q;
  logic                            conf_edge;
  logic                            sel_ok;
  logic                            denied_nxt;
  logic                            wr_en;
  logic [NUM_REGS*DATA_WIDTH-1:0]  data_q;

  assign conf_edge = confirm & ~confirm_q;
  assign sel_ok    = {1'b0, regSelect} < NUM_REGS_W;
  assign fail_inc  = fail_count + FW'(1);
  assign dataOut   = data_q;

  always_comb begin
    state_nxt  = state;
    fail_nxt   = fail_count;
    lock_nxt   = lock_count;
    denied_nxt = 1'b0;
    wr_en      = 1'b0;
    case (state)
      IDLE: begin
        if (request) state_nxt = CHECK;
      end
      CHECK: begin
        // Dropping request aborts the check without counting it as a try.
        if (!request) begin
          state_nxt = IDLE;
        end else if (conf_edge) begin
          if (key == PASSWORD) begin
            state_nxt = GRANTED;
            fail_nxt  = '0;
          end else begin
            denied_nxt = 1'b1;
            if (fail_inc == FW'(MAX_TRIES)) begin
              state_nxt = LOCKED;
              lock_nxt  = LW'(LOCK_CYCLES - 1);
              fail_nxt  = '0;
            end else begin
              state_nxt = IDLE;
              fail_nxt  = fail_inc;
            end
          end
        end
      end
      GRANTED: begin
        if (!request) begin
          state_nxt = IDLE;
        end else if (conf_edge) begin
          if (sel_ok) begin
            wr_en     = 1'b1;
            state_nxt = IDLE;
          end else begin
            denied_nxt = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (lock_count == '0) state_nxt = IDLE;
        else                  lock_nxt  = lock_count - LW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      fail_count <= '0;
      lock_count <= '0;
      confirm_q  <= 1'b0;
      data_q     <= '0;
      granted    <= 1'b0;
      denied     <= 1'b0;
      locked     <= 1'b0;
      writeDone  <= 1'b0;
    end else begin
      state      <= state_nxt;
      fail_count <= fail_nxt;
      lock_count <= lock_nxt;
      confirm_q  <= confirm;
      granted    <= (state_nxt == GRANTED);
      denied     <= denied_nxt;
      locked     <= (state_nxt == LOCKED);
      writeDone  <= wr_en;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en && (regSelect == SEL_WIDTH'(i)))
          data_q[i*DATA_WIDTH +: DATA_WIDTH] <= inputData;
      end
    end
  end

endmodule

// File: tb/tb_config_register_bank.sv
// Directed bench for config_register_bank with a 3-register bank (exercises an out-of-range select).
module tb_config_register_bank;

  logic        clock = 1'b0;
  logic        reset;
  logic        request;
  logic        confirm;
  logic [7:0]  key;
  logic [1:0]  regSelect;
  logic [6:0]  inputData;
  logic [20:0] dataOut;
  logic        granted, denied, locked, writeDone;

  int n_cmp = 0;
  int n_err = 0;
  logic [20:0] exp_data;

  config_register_bank #(.NUM_REGS(3)) dut (
    .clock(clock), .reset(reset), .request(request), .confirm(confirm),
    .key(key), .regSelect(regSelect), .inputData(inputData),
    .dataOut(dataOut), .granted(granted), .denied(denied),
    .locked(locked), .writeDone(writeDone)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wrong_session();
    request = 1'b1; tick();
    key = 8'h00; confirm = 1'b1; tick();
    confirm = 1'b0; request = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; request = 1'b0; confirm = 1'b0; key = 8'h00;
    regSelect = 2'd0; inputData = 7'h00;
    tick(); tick();
    reset = 1'b0;
    tick();
    n_cmp++; if (dataOut !== 21'h0) begin n_err++; $display("FAIL reset_data got=%h exp=0", dataOut); end
    n_cmp++; if ({granted, denied, locked, writeDone} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags got=%b exp=0000", {granted, denied, locked, writeDone}); end
  endtask

  task automatic test_grant_write();
    request = 1'b1; tick();
    key = 8'hA5; confirm = 1'b1; tick();
    n_cmp++; if (granted !== 1'b1) begin n_err++; $display("FAIL grant got=%b exp=1", granted); end
    confirm = 1'b0; tick();
    n_cmp++; if ({granted, writeDone} !== 2'b10) begin
      n_err++; $display("FAIL grant_hold got=%b exp=10", {granted, writeDone}); end
    regSelect = 2'd1; inputData = 7'h55; confirm = 1'b1; tick();
    exp_data = 21'h55 << 7;
    n_cmp++; if ({granted, writeDone} !== 2'b01) begin
      n_err++; $display("FAIL write_flags got=%b exp=01", {granted, writeDone}); end
    n_cmp++; if (dataOut !== exp_data) begin n_err++; $display("FAIL write_reg1 got=%h exp=%h", dataOut, exp_data); end
    confirm = 1'b0; request = 1'b0; tick();
    n_cmp++; if (writeDone !== 1'b0) begin n_err++; $display("FAIL write_pulse got=%b exp=0", writeDone); end
    n_cmp++; if (dataOut !== exp_data) begin n_err++; $display("FAIL write_stable got=%h exp=%h", dataOut, exp_data); end
  endtask

  task automatic test_lockout();
    for (int s = 0; s < 3; s++) begin
      request = 1'b1; tick();
      key = 8'h00; confirm = 1'b1; tick();
      n_cmp++; if (denied !== 1'b1) begin n_err++; $display("FAIL deny_%0d got=%b exp=1", s, denied); end
      n_cmp++; if (locked !== (s == 2)) begin n_err++; $display("FAIL lock_entry_%0d got=%b exp=%b", s, locked, s == 2); end
      if (s < 2) begin
        confirm = 1'b0; request = 1'b0; tick();
        n_cmp++; if (denied !== 1'b0) begin n_err++; $display("FAIL deny_pulse_%0d got=%b exp=0", s, denied); end
      end
    end
    for (int i = 1; i < 16; i++) begin
      request = 1'b1; key = 8'hA5; confirm = i[0];
      tick();
      n_cmp++; if ({locked, granted, denied} !== 3'b100) begin
        n_err++; $display("FAIL lock_cycle_%0d got=%b exp=100", i, {locked, granted, denied}); end
    end
    request = 1'b0; confirm = 1'b0; tick();
    n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL lock_release got=%b exp=0", locked); end
    request = 1'b1; tick();
    key = 8'hA5; confirm = 1'b1; tick();
    n_cmp++; if (granted !== 1'b1) begin n_err++; $display("FAIL regrant got=%b exp=1", granted); end
    confirm = 1'b0; request = 1'b0; tick();
    n_cmp++; if (granted !== 1'b0) begin n_err++; $display("FAIL drop_grant got=%b exp=0", granted); end
  endtask

  task automatic test_abort();
    wrong_session(); tick();
    wrong_session(); tick();
    request = 1'b1; tick();
    request = 1'b0; key = 8'h00; confirm = 1'b1; tick();
    n_cmp++; if ({denied, granted, locked} !== 3'b000) begin
      n_err++; $display("FAIL abort got=%b exp=000", {denied, granted, locked}); end
    confirm = 1'b0; tick();
    request = 1'b1; tick();
    key = 8'h00; confirm = 1'b1; tick();
    n_cmp++; if ({denied, locked} !== 2'b11) begin
      n_err++; $display("FAIL abort_count got=%b exp=11", {denied, locked}); end
    confirm = 1'b0; request = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL abort_unlock got=%b exp=0", locked); end
  endtask

  task automatic test_bad_select();
    request = 1'b1; tick();
    key = 8'hA5; confirm = 1'b1; tick();
    confirm = 1'b0; tick();
    regSelect = 2'd3; inputData = 7'h11; confirm = 1'b1; tick();
    n_cmp++; if ({denied, granted, writeDone} !== 3'b110) begin
      n_err++; $display("FAIL badsel_flags got=%b exp=110", {denied, granted, writeDone}); end
    n_cmp++; if (dataOut !== exp_data) begin n_err++; $display("FAIL badsel_nowrite got=%h exp=%h", dataOut, exp_data); end
    confirm = 1'b0; tick();
    n_cmp++; if ({denied, granted} !== 2'b01) begin
      n_err++; $display("FAIL badsel_stay got=%b exp=01", {denied, granted}); end
    regSelect = 2'd2; inputData = 7'h7F; confirm = 1'b1; tick();
    exp_data = (21'h7F << 14) | (21'h55 << 7);
    n_cmp++; if ({granted, writeDone} !== 2'b01) begin
      n_err++; $display("FAIL reg2_flags got=%b exp=01", {granted, writeDone}); end
    n_cmp++; if (dataOut !== exp_data) begin n_err++; $display("FAIL reg2_data got=%h exp=%h", dataOut, exp_data); end
    confirm = 1'b0; request = 1'b0; tick();
  endtask

  task automatic test_back_to_back();
    request = 1'b1; tick();
    key = 8'hA5; confirm = 1'b1; tick();
    confirm = 1'b0; tick();
    regSelect = 2'd0; inputData = 7'h2A; confirm = 1'b1; tick();
    exp_data = (21'h7F << 14) | (21'h55 << 7) | 21'h2A;
    n_cmp++; if (dataOut !== exp_data) begin n_err++; $display("FAIL held_first got=%h exp=%h", dataOut, exp_data); end
    inputData = 7'h01;
    for (int i = 0; i < 9; i++) begin
      tick();
      n_cmp++; if ({writeDone, granted} !== 2'b00 || dataOut !== exp_data) begin
        n_err++; $display("FAIL held_%0d got=%b/%h exp=00/%h", i, {writeDone, granted}, dataOut, exp_data); end
    end
    confirm = 1'b0; tick();
    key = 8'hA5; confirm = 1'b1; tick();
    n_cmp++; if (granted !== 1'b1) begin n_err++; $display("FAIL pre_reset_grant got=%b exp=1", granted); end
    reset = 1'b1; #2;
    n_cmp++; if (granted !== 1'b0 || dataOut !== 21'h0) begin
      n_err++; $display("FAIL async_reset got=%b/%h exp=0/0", granted, dataOut); end
    tick();
    reset = 1'b0; request = 1'b0; confirm = 1'b0; tick();
    n_cmp++; if ({granted, denied, locked, writeDone} !== 4'b0000 || dataOut !== 21'h0) begin
      n_err++; $display("FAIL post_reset got=%b/%h exp=0000/0", {granted, denied, locked, writeDone}, dataOut); end
  endtask

  initial begin
    test_reset();
    test_grant_write();
    test_lockout();
    test_abort();
    test_bad_select();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
